// File: rtl/bf16_pkg.sv
// Shared bf16 constants and the reduction sequencer state encoding.
package bf16_pkg;

  localparam int BF16_W = 16;
  localparam logic [BF16_W-1:0] BF16_POS_ZERO = 16'h0000;
  localparam logic [BF16_W-1:0] BF16_ONE      = 16'h3F80;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_FIRST = 3'd1,
    LOAD_NEXT  = 3'd2,
    ISSUE      = 3'd3,
    WAIT_SUM   = 3'd4,
    PUT_RESULT = 3'd5
  } seq_state_t;

endpackage

// File: rtl/bf16_reduce_seq.sv
// Sequential bf16 vector reducer: pulls N elements and folds them through an
// external adder over STB/BUSY handshakes, then presents the final sum.
module bf16_reduce_seq
  import bf16_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CNT_W-1:0]  cmd_len,
  input  logic              cmd_STB,
  output logic              cmd_BUSY,
  input  logic [BF16_W-1:0] in_data,
  input  logic              in_STB,
  output logic              in_BUSY,
  output logic [BF16_W-1:0] add_a,
  output logic [BF16_W-1:0] add_b,
  output logic              add_STB,
  input  logic              adder_BUSY,
  input  logic [BF16_W-1:0] adder_sum,
  input  logic              adder_output_STB,
  output logic              sum_BUSY,
  output logic [BF16_W-1:0] result,
  output logic              result_STB,
  input  logic              result_module_BUSY
);

  seq_state_t        state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [BF16_W-1:0] acc_r, acc_s;
  logic [BF16_W-1:0] opnd_r, opnd_s;

  logic cmd_fire_s, in_fire_s, add_fire_s, sum_fire_s, res_fire_s;

  assign cmd_fire_s = cmd_STB & ~cmd_BUSY;
  assign in_fire_s  = in_STB & ~in_BUSY;
  assign add_fire_s = add_STB & ~adder_BUSY;
  assign sum_fire_s = adder_output_STB & ~sum_BUSY;
  assign res_fire_s = result_STB & ~result_module_BUSY;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    acc_s   = acc_r;
    opnd_s  = opnd_r;
    case (state_r)
      IDLE: begin
        if (cmd_fire_s) begin
          cnt_s = cmd_len;
          if (cmd_len == {CNT_W{1'b0}}) begin
            acc_s   = BF16_POS_ZERO;
            state_s = PUT_RESULT;
          end else begin
            state_s = LOAD_FIRST;
          end
        end else begin
          state_s = IDLE;
        end
      end
      LOAD_FIRST: begin
        if (in_fire_s) begin
          acc_s   = in_data;
          cnt_s   = cnt_r - CNT_W'(1);
          state_s = (cnt_r == CNT_W'(1)) ? PUT_RESULT : LOAD_NEXT;
        end else begin
          state_s = LOAD_FIRST;
        end
      end
      LOAD_NEXT: begin
        if (in_fire_s) begin
          opnd_s  = in_data;
          cnt_s   = cnt_r - CNT_W'(1);
          state_s = ISSUE;
        end else begin
          state_s = LOAD_NEXT;
        end
      end
      ISSUE: begin
        if (add_fire_s) begin
          state_s = WAIT_SUM;
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT_SUM: begin
        if (sum_fire_s) begin
          acc_s   = adder_sum;
          state_s = (cnt_r == {CNT_W{1'b0}}) ? PUT_RESULT : LOAD_NEXT;
        end else begin
          state_s = WAIT_SUM;
        end
      end
      PUT_RESULT: begin
        if (res_fire_s) begin
          state_s = IDLE;
        end else begin
          state_s = PUT_RESULT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Datapath registers and handshake outputs decoded from the next state,
  // so every STB/BUSY lines up with the state it belongs to
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r      <= {CNT_W{1'b0}};
      acc_r      <= BF16_POS_ZERO;
      opnd_r     <= BF16_POS_ZERO;
      cmd_BUSY   <= 1'b0;
      in_BUSY    <= 1'b1;
      add_STB    <= 1'b0;
      sum_BUSY   <= 1'b1;
      result_STB <= 1'b0;
      add_a      <= BF16_POS_ZERO;
      add_b      <= BF16_POS_ZERO;
      result     <= BF16_POS_ZERO;
    end else begin
      cnt_r      <= cnt_s;
      acc_r      <= acc_s;
      opnd_r     <= opnd_s;
      cmd_BUSY   <= (state_s != IDLE);
      in_BUSY    <= !((state_s == LOAD_FIRST) || (state_s == LOAD_NEXT));
      add_STB    <= (state_s == ISSUE);
      sum_BUSY   <= (state_s != WAIT_SUM);
      result_STB <= (state_s == PUT_RESULT);
      add_a      <= acc_s;
      add_b      <= opnd_s;
      result     <= acc_s;
    end
  end

endmodule

// File: tb/tb_bf16_reduce_seq.sv
// Directed bench for bf16_reduce_seq with a behavioural table-driven adder.
module tb_bf16_reduce_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  cmd_len = 8'd0;
  logic        cmd_STB = 1'b0;
  logic        cmd_BUSY;
  logic [15:0] in_data = 16'h0000;
  logic        in_STB = 1'b0;
  logic        in_BUSY;
  logic [15:0] add_a, add_b;
  logic        add_STB;
  logic        adder_BUSY;
  logic [15:0] adder_sum;
  logic        adder_output_STB;
  logic        sum_BUSY;
  logic [15:0] result;
  logic        result_STB;
  logic        result_module_BUSY = 1'b0;

  int checks = 0;
  int errors = 0;
  int in_cnt = 0;
  int add_cnt = 0;
  int viol_cnt = 0;
  logic [15:0] log_a [0:15];
  logic [15:0] log_b [0:15];

  always #5 clk = ~clk;

  bf16_reduce_seq #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_len(cmd_len), .cmd_STB(cmd_STB), .cmd_BUSY(cmd_BUSY),
    .in_data(in_data), .in_STB(in_STB), .in_BUSY(in_BUSY),
    .add_a(add_a), .add_b(add_b), .add_STB(add_STB),
    .adder_BUSY(adder_BUSY), .adder_sum(adder_sum),
    .adder_output_STB(adder_output_STB), .sum_BUSY(sum_BUSY),
    .result(result), .result_STB(result_STB),
    .result_module_BUSY(result_module_BUSY)
  );

  // Hand-computed bf16 sums for the operand pairs this bench produces
  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3F80_4000: return 16'h4040;
      32'h4040_4040: return 16'h40C0;
      32'h3F00_3F00: return 16'h3F80;
      32'h3F80_3F80: return 16'h4000;
      32'h4000_3F80: return 16'h4040;
      32'h4040_3F80: return 16'h4080;
      32'h4000_BF80: return 16'h3F80;
      default:       return 16'hFFFF;
    endcase
  endfunction

  // Behavioural adder, reset from inverted rst, with a post-result busy cycle
  logic adder_rst;
  int   ph;
  assign adder_rst = ~rst;
  always @(posedge clk or posedge adder_rst) begin
    if (adder_rst) begin
      adder_BUSY       <= 1'b0;
      adder_output_STB <= 1'b0;
      adder_sum        <= 16'h0000;
      ph               <= 0;
    end else begin
      case (ph)
        0: if (add_STB && !adder_BUSY) begin
             adder_BUSY <= 1'b1;
             adder_sum  <= ref_add(add_a, add_b);
             ph         <= 1;
           end
        1: ph <= 2;
        2: begin adder_output_STB <= 1'b1; ph <= 3; end
        3: if (!sum_BUSY) begin adder_output_STB <= 1'b0; ph <= 4; end
        4: begin adder_BUSY <= 1'b0; ph <= 0; end
        default: ph <= 0;
      endcase
    end
  end

  // Transfer monitor
  always @(posedge clk) begin
    if (rst) begin
      if (in_STB && !in_BUSY) in_cnt <= in_cnt + 1;
      if (add_STB && !adder_BUSY) begin
        if (add_cnt < 16) begin
          log_a[add_cnt] <= add_a;
          log_b[add_cnt] <= add_b;
        end
        add_cnt <= add_cnt + 1;
      end
      if ((add_STB || !sum_BUSY) && !in_BUSY) viol_cnt <= viol_cnt + 1;
    end
  end

  task automatic send_cmd(input logic [7:0] len);
    int t = 0;
    cmd_len = len;
    cmd_STB = 1'b1;
    while (cmd_BUSY !== 1'b0 && t < 500) begin @(posedge clk); #1; t++; end
    if (t >= 500) begin
      checks++; errors++;
      $display("FAIL cmd_timeout: cmd_BUSY=%b, required 0 within 500 cycles", cmd_BUSY);
    end
    @(posedge clk); #1;
    cmd_STB = 1'b0;
  endtask

  task automatic send_elem(input logic [15:0] d, input int gap);
    int t = 0;
    repeat (gap) begin @(posedge clk); #1; end
    in_data = d;
    in_STB  = 1'b1;
    while (in_BUSY !== 1'b0 && t < 500) begin @(posedge clk); #1; t++; end
    if (t >= 500) begin
      checks++; errors++;
      $display("FAIL elem_timeout: in_BUSY=%b, required 0 within 500 cycles", in_BUSY);
    end
    @(posedge clk); #1;
    in_STB = 1'b0;
  endtask

  task automatic take_result(input string name, input logic [15:0] exp);
    int t = 0;
    result_module_BUSY = 1'b0;
    while (result_STB !== 1'b1 && t < 500) begin @(posedge clk); #1; t++; end
    checks++;
    if (result_STB !== 1'b1 || result !== exp) begin
      errors++;
      $display("FAIL %s: result_STB=%b result=%h, required 1 / %h", name, result_STB, result, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({cmd_BUSY, in_BUSY, add_STB, sum_BUSY, result_STB} !== 5'b01010 ||
        result !== 16'h0000 || add_a !== 16'h0000 || add_b !== 16'h0000) begin
      errors++;
      $display("FAIL %s: busy/stb=%b%b%b%b%b result=%h add_a=%h add_b=%h, required 01010 / 0000 / 0000 / 0000",
               name, cmd_BUSY, in_BUSY, add_STB, sum_BUSY, result_STB, result, add_a, add_b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_values");
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_len3();
    int b = add_cnt;
    send_cmd(8'd3);
    send_elem(16'h3F80, 0);
    send_elem(16'h4000, 0);
    send_elem(16'h4040, 0);
    take_result("len3_result", 16'h40C0);
    checks++;
    if (add_cnt - b !== 2) begin
      errors++;
      $display("FAIL len3_add_count: got %0d, required 2", add_cnt - b);
    end
    checks++;
    if (log_a[b] !== 16'h3F80 || log_b[b] !== 16'h4000 ||
        log_a[b+1] !== 16'h4040 || log_b[b+1] !== 16'h4040) begin
      errors++;
      $display("FAIL len3_operands: (%h,%h) (%h,%h), required (3f80,4000) (4040,4040)",
               log_a[b], log_b[b], log_a[b+1], log_b[b+1]);
    end
  endtask

  task automatic test_len0();
    int bi = in_cnt;
    int ba = add_cnt;
    in_data = 16'h1234;
    in_STB  = 1'b1;
    result_module_BUSY = 1'b1;
    send_cmd(8'd0);
    checks++;
    if (result_STB !== 1'b1 || result !== 16'h0000) begin
      errors++;
      $display("FAIL len0_latency: result_STB=%b result=%h one cycle after cmd, required 1 / 0000",
               result_STB, result);
    end
    take_result("len0_result", 16'h0000);
    in_STB = 1'b0;
    checks++;
    if (in_cnt !== bi || add_cnt !== ba) begin
      errors++;
      $display("FAIL len0_no_transfers: in=%0d add=%0d, required 0 / 0", in_cnt - bi, add_cnt - ba);
    end
  endtask

  task automatic test_len1();
    int ba = add_cnt;
    result_module_BUSY = 1'b1;
    send_cmd(8'd1);
    send_elem(16'hBF80, 0);
    checks++;
    if (result_STB !== 1'b1) begin
      errors++;
      $display("FAIL len1_latency: result_STB=%b one cycle after element, required 1", result_STB);
    end
    take_result("len1_result", 16'hBF80);
    checks++;
    if (add_cnt !== ba) begin
      errors++;
      $display("FAIL len1_no_add: add transfers=%0d, required 0", add_cnt - ba);
    end
  endtask

  task automatic test_backpressure();
    int t = 0;
    result_module_BUSY = 1'b1;
    send_cmd(8'd2);
    send_elem(16'h3F00, 0);
    send_elem(16'h3F00, 0);
    while (result_STB !== 1'b1 && t < 500) begin @(posedge clk); #1; t++; end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (result_STB !== 1'b1 || result !== 16'h3F80 || cmd_BUSY !== 1'b1) begin
        errors++;
        $display("FAIL hold_cycle%0d: result_STB=%b result=%h cmd_BUSY=%b, required 1 / 3f80 / 1",
                 i, result_STB, result, cmd_BUSY);
      end
      @(posedge clk); #1;
    end
    take_result("hold_release", 16'h3F80);
    checks++;
    if (cmd_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle: cmd_BUSY=%b after result transfer, required 0", cmd_BUSY);
    end
  endtask

  task automatic test_gaps();
    int bv = viol_cnt;
    int ba = add_cnt;
    send_cmd(8'd4);
    for (int i = 0; i < 4; i++) send_elem(16'h3F80, $urandom_range(0, 5));
    take_result("gaps_result", 16'h4080);
    checks++;
    if (viol_cnt !== bv || add_cnt - ba !== 3) begin
      errors++;
      $display("FAIL gaps_in_busy: in_BUSY low during add phase %0d times, add transfers %0d, required 0 / 3",
               viol_cnt - bv, add_cnt - ba);
    end
  endtask

  task automatic test_reset_mid_op();
    int t = 0;
    send_cmd(8'd3);
    send_elem(16'h3F80, 0);
    send_elem(16'h4000, 0);
    while (sum_BUSY !== 1'b0 && t < 500) begin @(posedge clk); #1; t++; end
    checks++;
    if (sum_BUSY !== 1'b0) begin
      errors++;
      $display("FAIL mid_reach_wait_sum: sum_BUSY=%b, required 0", sum_BUSY);
    end
    #2 rst = 1'b0;
    #1;
    check_reset_outputs("mid_reset_async");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    send_cmd(8'd2);
    send_elem(16'h4000, 0);
    send_elem(16'hBF80, 0);
    take_result("after_reset_result", 16'h3F80);
  endtask

  initial begin
    test_reset();
    test_len3();
    test_len0();
    test_len1();
    test_backpressure();
    test_gaps();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
